// File: rtl/jtframe_vtimer_pkg.sv
// jtframe_vtimer_pkg: default video timing constants and modulo-range add shared by the timer (JTFRAME_VTIMER_OFS_EN)
package jtframe_vtimer_pkg;
  localparam int DEF_HW = 9;
  localparam int DEF_VW = 9;
  localparam int DEF_HCNT_START = 0;
  localparam int DEF_HCNT_END = 383;
  localparam int DEF_HB_START = 288;
  localparam int DEF_HB_END = 0;
  localparam int DEF_HS_START = 312;
  localparam int DEF_HS_END = 344;
  localparam int DEF_V_START = 0;
  localparam int DEF_V_END = 263;
  localparam int DEF_VB_START = 224;
  localparam int DEF_VB_END = 0;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_END = 243;
  localparam int DEF_VRENDER_AHEAD = 1;
  localparam int VRENDER_AHEAD_MAX = 4;
  localparam int DW = 6;
  function automatic int wrap_add(input int a, input int d, input int lo, input int hi);
    int n;
    int s;
    n = hi - lo + 1;
    s = a - lo + d;
    s = s < 0 ? s + n : s >= n ? s - n : s;
    return s + lo;
  endfunction
  function automatic int clamp_ahead(input int a);
    return a < 1 ? 1 : a > VRENDER_AHEAD_MAX ? VRENDER_AHEAD_MAX : a;
  endfunction
endpackage

// File: rtl/jtframe_vtimer_wrap.sv
// jtframe_vtimer_wrap: adds a small signed delta to a counter value, wrapping within LO..HI
module jtframe_vtimer_wrap
  import jtframe_vtimer_pkg::*;
#(
  parameter int W = 9,
  parameter int LO = 0,
  parameter int HI = 383
) (
  input  logic [W-1:0]         a,
  input  logic signed [DW-1:0] d,
  output logic [W-1:0]         y
);
  always_comb y = W'(wrap_add(int'(a), int'(d), LO, HI));
endmodule

// File: rtl/jtframe_vtimer_gen.sv
// jtframe_vtimer_gen: video timing generator with counters, blanking, syncs and vrender lead; JTFRAME_VTIMER_OFS_EN enables sync offsets
module jtframe_vtimer_gen
  import jtframe_vtimer_pkg::*;
#(
  parameter int HW = DEF_HW,
  parameter int VW = DEF_VW,
  parameter int HCNT_START = DEF_HCNT_START,
  parameter int HCNT_END = DEF_HCNT_END,
  parameter int HB_START = DEF_HB_START,
  parameter int HB_END = DEF_HB_END,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END = DEF_HS_END,
  parameter int V_START = DEF_V_START,
  parameter int V_END = DEF_V_END,
  parameter int VB_START = DEF_VB_START,
  parameter int VB_END = DEF_VB_END,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END = DEF_VS_END,
  parameter int VRENDER_AHEAD = DEF_VRENDER_AHEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic signed [3:0] hs_ofs,
  input  logic signed [3:0] vs_ofs,
  output logic [HW-1:0]     hdump,
  output logic [VW-1:0]     vdump,
  output logic [VW-1:0]     vrender,
  output logic [VW-1:0]     vrender1,
  output logic              lhbl,
  output logic              lvbl,
  output logic              hs,
  output logic              vs,
  output logic              hinit,
  output logic              vinit
);
  localparam int AHEAD = clamp_ahead(VRENDER_AHEAD);
  localparam logic [HW-1:0] H0 = HW'(HCNT_START);
  localparam logic [HW-1:0] H1 = HW'(HCNT_END);
  localparam logic [HW-1:0] HBS = HW'(HB_START);
  localparam logic [HW-1:0] HBE = HW'(HB_END);
  localparam logic [HW-1:0] HSS = HW'(HS_START);
  localparam logic [HW-1:0] HSE = HW'(HS_END);
  localparam logic [VW-1:0] V0 = VW'(V_START);
  localparam logic [VW-1:0] V1 = VW'(V_END);
  localparam logic [VW-1:0] VBS = VW'(VB_START);
  localparam logic [VW-1:0] VBE = VW'(VB_END);
  localparam logic [VW-1:0] VSS = VW'(VS_START);
  localparam logic [VW-1:0] VSE = VW'(VS_END);
  localparam logic [VW-1:0] VR_RST = VW'(wrap_add(V_START, AHEAD, V_START, V_END));
  localparam logic [VW-1:0] VR1_RST = VW'(wrap_add(V_START, AHEAD + 1, V_START, V_END));
  localparam logic signed [DW-1:0] D_AHEAD = DW'(AHEAD);
  localparam logic signed [DW-1:0] D_AHEAD1 = DW'(AHEAD + 1);
  logic hwrap;
  logic [HW-1:0] nh, hs_on, hs_off;
  logic [VW-1:0] nv, vr_nxt, vr1_nxt, vs_on, vs_off;
  logic signed [3:0] hofs, vofs;
  logic signed [DW-1:0] hd, vd;
  always_comb begin
    hwrap = hdump == H1;
    nh = hwrap ? H0 : hdump + 1'd1;
    nv = !hwrap ? vdump : vdump == V1 ? V0 : vdump + 1'd1;
    hd = {{(DW-4){hofs[3]}}, hofs};
    vd = {{(DW-4){vofs[3]}}, vofs};
  end
  jtframe_vtimer_wrap #(.W(VW), .LO(V_START), .HI(V_END)) u_vr (.a(nv), .d(D_AHEAD), .y(vr_nxt));
  jtframe_vtimer_wrap #(.W(VW), .LO(V_START), .HI(V_END)) u_vr1 (.a(nv), .d(D_AHEAD1), .y(vr1_nxt));
  jtframe_vtimer_wrap #(.W(HW), .LO(HCNT_START), .HI(HCNT_END)) u_hs_on (.a(HSS), .d(hd), .y(hs_on));
  jtframe_vtimer_wrap #(.W(HW), .LO(HCNT_START), .HI(HCNT_END)) u_hs_off (.a(HSE), .d(hd), .y(hs_off));
  jtframe_vtimer_wrap #(.W(VW), .LO(V_START), .HI(V_END)) u_vs_on (.a(VSS), .d(vd), .y(vs_on));
  jtframe_vtimer_wrap #(.W(VW), .LO(V_START), .HI(V_END)) u_vs_off (.a(VSE), .d(vd), .y(vs_off));
`ifdef JTFRAME_VTIMER_OFS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hofs <= '0;
      vofs <= '0;
    end else if (pxl_cen && nh == H0 && nv == V0) begin
      hofs <= hs_ofs;
      vofs <= vs_ofs;
    end
`else
  logic ofs_unused;
  assign hofs = '0;
  assign vofs = '0;
  assign ofs_unused = ^{hs_ofs, vs_ofs};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hdump <= H0;
      vdump <= V0;
      vrender <= VR_RST;
      vrender1 <= VR1_RST;
      lhbl <= 1'b0;
      lvbl <= 1'b0;
      hs <= 1'b0;
      vs <= 1'b0;
      hinit <= 1'b0;
      vinit <= 1'b0;
    end else if (pxl_cen) begin
      hdump <= nh;
      vdump <= nv;
      vrender <= vr_nxt;
      vrender1 <= vr1_nxt;
      hinit <= nh == H0;
      vinit <= nh == H0 && nv == V0;
      lhbl <= nh == HBS ? 1'b0 : nh == HBE ? 1'b1 : lhbl;
      lvbl <= nh != HBS ? lvbl : nv == VBS ? 1'b0 : nv == VBE ? 1'b1 : lvbl;
      hs <= nh == hs_on ? 1'b1 : nh == hs_off ? 1'b0 : hs;
      vs <= nh != hs_on ? vs : nv == vs_on ? 1'b1 : nv == vs_off ? 1'b0 : vs;
    end
endmodule

// File: doc/jtframe_vtimer_gen.md
JTFRAME_VTIMER_GEN -- requirements
Module: jtframe_vtimer_gen

Interface
REQ-001 SHALL have parameter HW, default 9: width of the horizontal counter.
REQ-002 SHALL have parameter VW, default 9: width of the vertical counter.
REQ-003 SHALL have parameters HCNT_START/HCNT_END, defaults 0/383: hdump range, inclusive.
REQ-004 SHALL have parameters HB_START/HB_END, defaults 288/0: lhbl falls at HB_START and rises at HB_END.
REQ-005 SHALL have parameters HS_START/HS_END, defaults 312/344: hs is high from HS_START to HS_END-1.
REQ-006 SHALL have parameters V_START/V_END, defaults 0/263: vdump range, inclusive.
REQ-007 SHALL have parameters VB_START/VB_END, defaults 224/0; VS_START/VS_END, defaults 240/243.
REQ-008 SHALL have parameter VRENDER_AHEAD, default 1, range 1..4: vrender lead over vdump, in lines.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-011 SHALL have port pxl_cen, input, 1 bit: pixel clock enable.
REQ-012 SHALL have ports hdump (output, HW bits) and vdump, vrender, vrender1 (output, VW bits each).
REQ-013 SHALL have ports lhbl, lvbl, hs, vs, hinit, vinit (output, 1 bit each).
REQ-014 SHALL have ports hs_ofs, vs_ofs (input, 4 bits each, signed): sync position adjust.

Function
REQ-015 All outputs SHALL be registered and SHALL change only in a clk cycle where pxl_cen=1.
REQ-016 hdump SHALL increment by 1 per pxl_cen and wrap from HCNT_END to HCNT_START.
REQ-017 hinit SHALL be 1 for exactly the pixel where hdump==HCNT_START.
REQ-018 vdump SHALL increment when hdump wraps, and SHALL wrap from V_END to V_START.
REQ-019 vinit SHALL be 1 for exactly the pixel where vdump==V_START and hdump==HCNT_START.
REQ-020 vrender SHALL equal vdump+VRENDER_AHEAD, wrapped modulo the V_START..V_END range.
REQ-021 vrender1 SHALL equal vrender+1, wrapped the same way.
REQ-022 lhbl SHALL go 0 when hdump==HB_START and 1 when hdump==HB_END.
REQ-023 lvbl SHALL go 0 when vdump==VB_START and 1 when vdump==VB_END; both lvbl edges SHALL coincide with hdump==HB_START.
REQ-024 hs SHALL assert at HS_START+hs_ofs and deassert at HS_END+hs_ofs; additions SHALL wrap within the h range.
REQ-025 vs SHALL assert on line VS_START+vs_ofs and deassert on line VS_END+vs_ofs; both vs edges SHALL coincide with the hs rising edge.
REQ-026 hs_ofs and vs_ofs SHALL be sampled only on the vinit pixel; a change mid-frame SHALL take effect from the next frame.
REQ-027 When pxl_cen stays 0, all state SHALL hold indefinitely.

Reset
REQ-028 While rst_n=0, the block SHALL hold: hdump=HCNT_START, vdump=V_START, vrender=V_START+VRENDER_AHEAD, vrender1=vrender+1, lhbl=lvbl=0, hs=vs=0, hinit=vinit=0, latched offsets=0.
REQ-029 Reset asserted mid-frame SHALL clear the block immediately (asynchronously).
REQ-030 After rst_n rises, the first pxl_cen SHALL advance hdump to HCNT_START+1.

Configuration
REQ-031 With JTFRAME_VTIMER_OFS_EN defined, the offset logic of REQ-024 to REQ-026 SHALL be present.
REQ-032 Without JTFRAME_VTIMER_OFS_EN, hs_ofs and vs_ofs SHALL be ignored and the offsets SHALL be fixed at 0.

Structure
REQ-033 The default timing constants and the VRENDER_AHEAD limit SHALL live in the shared package jtframe_vtimer_pkg.
REQ-034 A sub-module jtframe_vtimer_wrap SHALL perform the modulo-range add for vrender, vrender1 and the sync offsets.

Verification
REQ-035 Defaults, 2 frames -> 384 pixels per line, 264 lines per frame; vinit exactly once per frame; hs high for 32 pixels; vs high for 3 lines.
REQ-036 vdump=263, hdump=383, one pxl_cen -> vdump=0, hdump=0; vinit=1 and hinit=1 for that pixel.
REQ-037 VRENDER_AHEAD=2, vdump=262 -> vrender=0 and vrender1=1.
REQ-038 OFS_EN defined, hs_ofs=-2 written mid-frame -> hs rise stays at 312 for the current frame and moves to 310 from the next vinit.
REQ-039 rst_n pulsed low at hdump=200 -> all outputs take their REQ-028 values without any clk edge.
REQ-040 pxl_cen held 0 for 50 cycles -> no output changes.
